// File: rtl/alu_seq.sv
// alu_seq: registered N-bit ALU with valid/ready handshakes on both sides,
// a persistent carry flag for multi-word arithmetic and an iterative
// shift-add multiplier that produces a 2N-bit product over N cycles.
module alu_seq #(
  parameter int N = 8
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [3:0]   SEL,
  input  logic         IN_VALID,
  output logic         IN_READY,
  output logic [N-1:0] SUM,
  output logic [N-1:0] HI,
  output logic         CarryOut,
  output logic         ZERO,
  output logic         NEG,
  output logic         OVF,
  output logic         OUT_VALID,
  input  logic         OUT_READY
);

  localparam int CW = $clog2(N + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_ADDC = 4'd2;
  localparam logic [3:0] OP_SUBB = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_ROL  = 4'd10;
  localparam logic [3:0] OP_ROR  = 4'd11;
  localparam logic [3:0] OP_INC  = 4'd12;
  localparam logic [3:0] OP_DEC  = 4'd13;
  localparam logic [3:0] OP_MUL  = 4'd14;
  localparam logic [3:0] OP_CMP  = 4'd15;

  // Signed overflow of a+b: operands agree in sign but the result does not.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  // Signed overflow of a-b: operands differ in sign and the result sign
  // differs from a.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb != b_msb) && (r_msb != a_msb);
  endfunction

  logic [0:0]     state_r;
  logic [CW-1:0]  cnt_r;
  logic [2*N-1:0] acc_r;
  logic [2*N-1:0] mcand_r;
  logic [N-1:0]   mplier_r;
  logic           c_r;

  logic [N-1:0]   sum_r;
  logic [N-1:0]   hi_r;
  logic           zero_r;
  logic           neg_r;
  logic           ovf_r;
  logic           out_valid_r;

  logic           in_ready_s;
  logic           accept_s;
  logic [N:0]     a_ext_s;
  logic [N:0]     b_ext_s;
  logic [N:0]     one_ext_s;
  logic [N:0]     c_ext_s;
  logic [N:0]     wide_s;
  logic [N-1:0]   res_s;
  logic           c_s;
  logic           ovf_s;
  logic           zero_s;
  logic           neg_s;
  logic [2*N-1:0] acc_next_s;

  assign a_ext_s   = {1'b0, A};
  assign b_ext_s   = {1'b0, B};
  assign one_ext_s = {{N{1'b0}}, 1'b1};
  assign c_ext_s   = {{N{1'b0}}, c_r};

  assign in_ready_s = RST_N && (state_r == ST_IDLE) && (!out_valid_r || OUT_READY);
  assign accept_s   = IN_VALID && in_ready_s;

  // Partial-product accumulation for the current multiply step.
  assign acc_next_s = acc_r + (mplier_r[0] ? mcand_r : {(2*N){1'b0}});

  // Single-cycle datapath: result and flags for the opcode on the inputs.
  always_comb begin
    wide_s = {(N+1){1'b0}};
    res_s  = {N{1'b0}};
    c_s    = 1'b0;
    ovf_s  = 1'b0;
    zero_s = 1'b0;
    neg_s  = 1'b0;
    case (SEL)
      OP_ADD: begin
        wide_s = a_ext_s + b_ext_s;
        res_s  = wide_s[N-1:0];
        c_s    = wide_s[N];
        ovf_s  = add_ovf(A[N-1], B[N-1], wide_s[N-1]);
      end
      OP_SUB, OP_CMP: begin
        wide_s = a_ext_s - b_ext_s;
        res_s  = (SEL == OP_CMP) ? A : wide_s[N-1:0];
        c_s    = wide_s[N];
        ovf_s  = sub_ovf(A[N-1], B[N-1], wide_s[N-1]);
      end
      OP_ADDC: begin
        wide_s = a_ext_s + b_ext_s + c_ext_s;
        res_s  = wide_s[N-1:0];
        c_s    = wide_s[N];
        ovf_s  = add_ovf(A[N-1], B[N-1], wide_s[N-1]);
      end
      OP_SUBB: begin
        wide_s = a_ext_s - b_ext_s - c_ext_s;
        res_s  = wide_s[N-1:0];
        c_s    = wide_s[N];
        ovf_s  = sub_ovf(A[N-1], B[N-1], wide_s[N-1]);
      end
      OP_AND: res_s = A & B;
      OP_OR:  res_s = A | B;
      OP_XOR: res_s = A ^ B;
      OP_NOT: res_s = ~A;
      OP_SHL: begin
        res_s = {A[N-2:0], 1'b0};
        c_s   = A[N-1];
      end
      OP_SHR: begin
        res_s = {1'b0, A[N-1:1]};
        c_s   = A[0];
      end
      OP_ROL: begin
        res_s = {A[N-2:0], A[N-1]};
        c_s   = A[N-1];
      end
      OP_ROR: begin
        res_s = {A[0], A[N-1:1]};
        c_s   = A[0];
      end
      OP_INC: begin
        wide_s = a_ext_s + one_ext_s;
        res_s  = wide_s[N-1:0];
        c_s    = wide_s[N];
        ovf_s  = add_ovf(A[N-1], 1'b0, wide_s[N-1]);
      end
      OP_DEC: begin
        wide_s = a_ext_s - one_ext_s;
        res_s  = wide_s[N-1:0];
        c_s    = wide_s[N];
        ovf_s  = sub_ovf(A[N-1], 1'b0, wide_s[N-1]);
      end
      default: begin
        // MUL is handled by the iterative path; nothing to compute here.
        res_s = {N{1'b0}};
      end
    endcase
    // CMP reports equality and the sign of A-B while passing A through.
    if (SEL == OP_CMP) begin
      zero_s = (A == B);
      neg_s  = wide_s[N-1];
    end else begin
      zero_s = (res_s == {N{1'b0}});
      neg_s  = res_s[N-1];
    end
  end

  // Control FSM, multiplier iteration and registered result/flags.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CW{1'b0}};
      acc_r       <= {(2*N){1'b0}};
      mcand_r     <= {(2*N){1'b0}};
      mplier_r    <= {N{1'b0}};
      c_r         <= 1'b0;
      sum_r       <= {N{1'b0}};
      hi_r        <= {N{1'b0}};
      zero_r      <= 1'b0;
      neg_r       <= 1'b0;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s && (SEL == OP_MUL)) begin
            // Latch operands; the old result (if any) is consumed this edge.
            state_r     <= ST_MUL;
            cnt_r       <= CW'(N);
            acc_r       <= {(2*N){1'b0}};
            mcand_r     <= {{N{1'b0}}, A};
            mplier_r    <= B;
            out_valid_r <= 1'b0;
          end else if (accept_s) begin
            sum_r       <= res_s;
            hi_r        <= {N{1'b0}};
            c_r         <= c_s;
            zero_r      <= zero_s;
            neg_r       <= neg_s;
            ovf_r       <= ovf_s;
            out_valid_r <= 1'b1;
          end else if (OUT_READY) begin
            out_valid_r <= 1'b0;
          end else begin
            out_valid_r <= out_valid_r;
          end
        end
        ST_MUL: begin
          acc_r    <= acc_next_s;
          mcand_r  <= {mcand_r[2*N-2:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[N-1:1]};
          cnt_r    <= cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            state_r     <= ST_IDLE;
            sum_r       <= acc_next_s[N-1:0];
            hi_r        <= acc_next_s[2*N-1:N];
            c_r         <= (acc_next_s[2*N-1:N] != {N{1'b0}});
            zero_r      <= (acc_next_s == {(2*N){1'b0}});
            neg_r       <= acc_next_s[N-1];
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b1;
          end else begin
            state_r <= ST_MUL;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign IN_READY  = in_ready_s;
  assign SUM       = sum_r;
  assign HI        = hi_r;
  assign CarryOut  = c_r;
  assign ZERO      = zero_r;
  assign NEG       = neg_r;
  assign OVF       = ovf_r;
  assign OUT_VALID = out_valid_r;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed-vector bench for alu_seq (N=8) with hand-computed
// expected values for arithmetic, flags, multiply, backpressure and reset.
module tb_alu_seq;

  logic       CLK;
  logic       RST_N;
  logic [7:0] A;
  logic [7:0] B;
  logic [3:0] SEL;
  logic       IN_VALID;
  logic       IN_READY;
  logic [7:0] SUM;
  logic [7:0] HI;
  logic       CarryOut;
  logic       ZERO;
  logic       NEG;
  logic       OVF;
  logic       OUT_VALID;
  logic       OUT_READY;

  int tests_run    = 0;
  int tests_failed = 0;

  alu_seq #(.N(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .A(A), .B(B), .SEL(SEL),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .SUM(SUM), .HI(HI), .CarryOut(CarryOut), .ZERO(ZERO), .NEG(NEG),
    .OVF(OVF), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Watchdog so a stuck run still ends with a report.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_res(input string tag, input logic [7:0] s, input logic [7:0] h,
                            input logic c, input logic z, input logic n, input logic v);
    check_eq({tag, ".valid"}, {31'd0, OUT_VALID}, 32'd1);
    check_eq({tag, ".sum"},   {24'd0, SUM}, {24'd0, s});
    check_eq({tag, ".hi"},    {24'd0, HI},  {24'd0, h});
    check_eq({tag, ".c"},     {31'd0, CarryOut}, {31'd0, c});
    check_eq({tag, ".z"},     {31'd0, ZERO}, {31'd0, z});
    check_eq({tag, ".n"},     {31'd0, NEG},  {31'd0, n});
    check_eq({tag, ".v"},     {31'd0, OVF},  {31'd0, v});
  endtask

  // Present one op, let it be accepted at the next edge, sample 1 unit later.
  task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    SEL = op; A = a; B = b; IN_VALID = 1'b1; OUT_READY = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0; A = 8'h00; B = 8'h00; SEL = 4'd0;
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check_eq("rst.in_ready", {31'd0, IN_READY}, 32'd0);
    check_eq("rst.valid",    {31'd0, OUT_VALID}, 32'd0);
    check_eq("rst.sum",      {24'd0, SUM}, 32'd0);
    check_eq("rst.hi",       {24'd0, HI}, 32'd0);
    check_eq("rst.flags",    {28'd0, CarryOut, ZERO, NEG, OVF}, 32'd0);
    RST_N = 1'b1;
    #1;
    check_eq("idle.in_ready", {31'd0, IN_READY}, 32'd1);

    // Single-cycle ops, back to back.
    do_op(4'd0,  8'h05, 8'h03); expect_res("add_basic", 8'h08, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op(4'd0,  8'hFF, 8'h01); expect_res("add_carry", 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    do_op(4'd2,  8'h00, 8'h00); expect_res("addc",      8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op(4'd1,  8'h03, 8'h05); expect_res("sub_neg",   8'hFE, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    do_op(4'd0,  8'h7F, 8'h01); expect_res("add_ovf",   8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    do_op(4'd8,  8'h81, 8'h00); expect_res("shl",       8'h02, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    do_op(4'd11, 8'h01, 8'h00); expect_res("ror",       8'h80, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    do_op(4'd15, 8'h05, 8'h05); expect_res("cmp_eq",    8'h05, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    do_op(4'd15, 8'h03, 8'h05); expect_res("cmp_lt",    8'h03, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    do_op(4'd13, 8'h80, 8'h00); expect_res("dec_ovf",   8'h7F, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    do_op(4'd12, 8'hFF, 8'h00); expect_res("inc_wrap",  8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    do_op(4'd3,  8'h00, 8'h00); expect_res("subb",      8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    do_op(4'd6,  8'hA5, 8'h0F); expect_res("xor",       8'hAA, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    do_op(4'd7,  8'h0F, 8'h00); expect_res("not",       8'hF0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

    // MUL 0xFF*0xFF; operands are scrambled during the iteration.
    do_op(4'd14, 8'hFF, 8'hFF);
    A = 8'h12; B = 8'h34; SEL = 4'd0; IN_VALID = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("mul.busy%0d", i), {30'd0, IN_READY, OUT_VALID}, 32'd0);
      @(posedge CLK); #1;
    end
    IN_VALID = 1'b0;
    expect_res("mul", 8'h01, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("mul.in_ready_after", {31'd0, IN_READY}, 32'd1);

    // Backpressure: pending MUL result must hold while OUT_READY is low.
    OUT_READY = 1'b0; SEL = 4'd0; A = 8'h10; B = 8'h20; IN_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      check_eq($sformatf("bp.in_ready%0d", i), {31'd0, IN_READY}, 32'd0);
      check_eq($sformatf("bp.hold%0d", i), {15'd0, OUT_VALID, HI, SUM}, {15'd0, 1'b1, 8'hFE, 8'h01});
    end
    OUT_READY = 1'b1;
    #1;
    check_eq("bp.release_ready", {31'd0, IN_READY}, 32'd1);
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    expect_res("bp.new", 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge CLK); #1;
    check_eq("drain.valid", {31'd0, OUT_VALID}, 32'd0);
    check_eq("drain.sum",   {24'd0, SUM}, 32'h30);

    // Reset in the third MUL cycle after setting the carry.
    do_op(4'd0, 8'hFF, 8'h01);
    check_eq("pre_rst.c", {31'd0, CarryOut}, 32'd1);
    do_op(4'd14, 8'h03, 8'h05);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST_N = 1'b0;
    @(posedge CLK); #1;
    check_eq("mulrst.in_ready", {31'd0, IN_READY}, 32'd0);
    check_eq("mulrst.outs", {11'd0, OUT_VALID, CarryOut, ZERO, NEG, OVF, HI, SUM}, 32'd0);
    RST_N = 1'b1;
    #1;
    check_eq("mulrst.idle", {31'd0, IN_READY}, 32'd1);
    repeat (10) @(posedge CLK);
    #1;
    check_eq("mulrst.no_result", {23'd0, OUT_VALID, SUM}, 32'd0);
    do_op(4'd2, 8'h01, 8'h01);
    expect_res("addc_after_rst", 8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
